// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage data memory access unit.
// Holds the access size codes, the controller state encoding and the
// helpers that turn an access into a misalignment flag, byte enables
// and lane-replicated store data.
package mem_access_unit_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        MAU_IDLE = 2'b00,
        MAU_REQ  = 2'b01,
        MAU_WAIT = 2'b10,
        MAU_DONE = 2'b11
    } mau_state_e;

    // Size 11 is treated as misaligned so it is rejected the same way.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = off[0];
            SIZE_W:  bad = off[1] | off[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SIZE_B:  be = 4'b0001 << off;
            SIZE_H:  be = 4'b0011 << {off[1], 1'b0};
            SIZE_W:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate the right-justified store data across every lane so the
    // memory picks the right bytes with the byte enables alone.
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            SIZE_B:  d = {4{wdata[7:0]}};
            SIZE_H:  d = {2{wdata[15:0]}};
            SIZE_W:  d = wdata;
            default: d = 32'h0000_0000;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load alignment: picks the addressed byte/half lane out of the returned
// memory word and zero- or sign-extends it to 32 bits.
// Ports: rdata (read word), lane (byte offset), size (access size code),
//        sext (1 = sign extend), result (aligned, extended value).
module mem_access_unit_load_align
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sext,
    output logic [31:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select followed by extension to the full word.
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        result = 32'h0000_0000;
        case (lane)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (lane[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (size)
            SIZE_B: begin
                if (sext) begin
                    result = {{24{byte_s[7]}}, byte_s};
                end else begin
                    result = {24'h00_0000, byte_s};
                end
            end
            SIZE_H: begin
                if (sext) begin
                    result = {{16{half_s[15]}}, half_s};
                end else begin
                    result = {16'h0000, half_s};
                end
            end
            SIZE_W:  result = rdata;
            default: result = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for the data memory. Accepts one load/store per
// instruction, issues a word-aligned request with byte enables over a
// req/gnt + rvalid handshake, returns aligned/extended load data and
// rejects misaligned accesses without touching memory.
// Ports: clk/reset (sync, active high); op_* pipeline request; stall to
//        the pipeline; ld_valid/ld_data load result; misalign reject
//        pulse; mem_* memory request channel and response.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    input  logic              op_load,
    input  logic              op_store,
    input  logic [1:0]        op_size,
    input  logic              op_sext,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [DATA_W-1:0] op_wdata,
    output logic              stall,
    output logic              ld_valid,
    output logic [DATA_W-1:0] ld_data,
    output logic              misalign,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    mau_state_e        state_r;
    mau_state_e        state_s;
    logic              accept_s;
    logic              bad_s;
    logic [31:0]       align_s;

    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [3:0]        be_r;
    logic [DATA_W-1:0] wdata_r;
    logic              sext_r;
    logic [1:0]        lane_r;
    logic [1:0]        size_r;
    logic              bad_r;
    logic [DATA_W-1:0] ld_data_r;

    assign accept_s = op_valid & (op_load | op_store);
    assign bad_s    = is_misaligned(op_size, op_addr[1:0]);

    // Next-state logic of the request controller.
    always_comb begin
        state_s = state_r;
        case (state_r)
            MAU_IDLE: begin
                if (accept_s) begin
                    if (bad_s) begin
                        state_s = MAU_DONE;
                    end else begin
                        state_s = MAU_REQ;
                    end
                end else begin
                    state_s = MAU_IDLE;
                end
            end
            MAU_REQ: begin
                if (mem_gnt) begin
                    if (we_r) begin
                        state_s = MAU_DONE;
                    end else begin
                        state_s = MAU_WAIT;
                    end
                end else begin
                    state_s = MAU_REQ;
                end
            end
            MAU_WAIT: begin
                if (mem_rvalid) begin
                    state_s = MAU_DONE;
                end else begin
                    state_s = MAU_WAIT;
                end
            end
            MAU_DONE: state_s = MAU_IDLE;
            default:  state_s = MAU_IDLE;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= MAU_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request fields captured at accept; they stay frozen through REQ so the
    // memory sees a stable request until it grants. A rejected access keeps
    // the previous request fields and only records the reject.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_r    <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            be_r    <= 4'b0000;
            wdata_r <= {DATA_W{1'b0}};
            sext_r  <= 1'b0;
            lane_r  <= 2'b00;
            size_r  <= 2'b00;
            bad_r   <= 1'b0;
        end else if (state_r == MAU_IDLE && accept_s) begin
            bad_r <= bad_s;
            if (!bad_s) begin
                we_r    <= op_store;
                addr_r  <= {op_addr[ADDR_W-1:2], 2'b00};
                be_r    <= byte_enables(op_size, op_addr[1:0]);
                wdata_r <= store_data(op_size, op_wdata);
                sext_r  <= op_sext;
                lane_r  <= op_addr[1:0];
                size_r  <= op_size;
            end
        end
    end

    mem_access_unit_load_align u_load_align (
        .rdata  (mem_rdata),
        .lane   (lane_r),
        .size   (size_r),
        .sext   (sext_r),
        .result (align_s)
    );

    // Load result register; rvalid outside WAIT is deliberately ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_data_r <= {DATA_W{1'b0}};
        end else if (state_r == MAU_WAIT && mem_rvalid) begin
            ld_data_r <= align_s;
        end
    end

    assign stall     = (state_r == MAU_REQ) | (state_r == MAU_WAIT) |
                       ((state_r == MAU_IDLE) & accept_s);
    assign mem_req   = (state_r == MAU_REQ);
    assign mem_we    = we_r;
    assign mem_addr  = addr_r;
    assign mem_be    = be_r;
    assign mem_wdata = wdata_r;
    assign ld_data   = ld_data_r;
    assign misalign  = (state_r == MAU_DONE) & bad_r;
    assign ld_valid  = (state_r == MAU_DONE) & ~bad_r & ~we_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus random
// loads/stores checked against a behavioural model of the access rules.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid, op_load, op_store, op_sext;
    logic [1:0]  op_size;
    logic [31:0] op_addr, op_wdata;
    logic        stall, ld_valid, misalign, mem_req, mem_we;
    logic [31:0] ld_data, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_ld = 32'h0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_load(op_load), .op_store(op_store),
        .op_size(op_size), .op_sext(op_sext), .op_addr(op_addr), .op_wdata(op_wdata),
        .stall(stall), .ld_valid(ld_valid), .ld_data(ld_data), .misalign(misalign),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---- reference model: plain arithmetic on the access rules ----
    function automatic bit ref_bad(input int size, input logic [31:0] addr);
        return (size == 3) || (size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0);
    endfunction

    function automatic logic [31:0] ref_be(input int size, input logic [31:0] addr);
        int off = int'(addr % 4);
        if (size == 0) return 32'(1 << off);
        if (size == 1) return 32'(3 << ((off / 2) * 2));
        return 32'd15;
    endfunction

    function automatic logic [31:0] ref_wdata(input int size, input logic [31:0] w);
        if (size == 0) return (w & 32'hFF) * 32'h0101_0101;
        if (size == 1) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input int size, input bit sext,
                                              input logic [31:0] addr, input logic [31:0] rd);
        int nbits;
        int sh;
        logic [31:0] v;
        logic [31:0] mask;
        if (size == 2) return rd;
        nbits = (size == 0) ? 8 : 16;
        sh    = (size == 0) ? 8 * int'(addr % 4) : 16 * int'((addr / 2) % 2);
        mask  = (32'h1 << nbits) - 32'h1;
        v     = (rd >> sh) & mask;
        if (sext && v[nbits-1]) v = v | ~mask;
        return v;
    endfunction

    // One complete op. Starts and ends at a negedge with op_valid low.
    task automatic run_op(input bit st, input int size, input bit sext,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int gd, input int rvd, input logic [31:0] rdata,
                          input bit spur);
        bit bad;
        bad      = ref_bad(size, addr);
        op_valid = 1'b1;
        op_store = st;
        op_load  = st ? 1'($urandom_range(0, 1)) : 1'b1;
        op_size  = 2'(size);
        op_sext  = sext;
        op_addr  = addr;
        op_wdata = wdata;
        #1;
        check_eq("accept_stall", 32'(stall), 32'd1);
        @(negedge clk);
        if (bad) begin
            check_eq("mis_pulse", 32'(misalign), 32'd1);
            check_eq("mis_req", 32'(mem_req), 32'd0);
            check_eq("mis_stall", 32'(stall), 32'd0);
            check_eq("mis_ldv", 32'(ld_valid), 32'd0);
            check_eq("mis_lddata", ld_data, exp_ld);
            op_valid = 1'b0;
            @(negedge clk);
            check_eq("mis_once", 32'(misalign), 32'd0);
            check_eq("mis_req2", 32'(mem_req), 32'd0);
            return;
        end
        for (int i = 0; i <= gd; i++) begin
            check_eq("req", 32'(mem_req), 32'd1);
            check_eq("req_stall", 32'(stall), 32'd1);
            check_eq("req_we", 32'(mem_we), 32'(st));
            check_eq("req_addr", mem_addr, addr & 32'hFFFF_FFFC);
            check_eq("req_be", 32'(mem_be), ref_be(size, addr));
            if (st) check_eq("req_wdata", mem_wdata, ref_wdata(size, wdata));
            mem_gnt    = (i == gd);
            mem_rvalid = spur && (i == 0);
            mem_rdata  = $urandom;
            @(negedge clk);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
        end
        if (st) begin
            check_eq("st_done_req", 32'(mem_req), 32'd0);
            check_eq("st_done_stall", 32'(stall), 32'd0);
            check_eq("st_done_ldv", 32'(ld_valid), 32'd0);
            check_eq("st_done_mis", 32'(misalign), 32'd0);
            op_valid = 1'b0;
            @(negedge clk);
            check_eq("st_idle_lddata", ld_data, exp_ld);
            return;
        end
        for (int j = 0; j <= rvd; j++) begin
            check_eq("wait_req", 32'(mem_req), 32'd0);
            check_eq("wait_stall", 32'(stall), 32'd1);
            check_eq("wait_ldv", 32'(ld_valid), 32'd0);
            mem_rvalid = (j == rvd);
            mem_rdata  = (j == rvd) ? rdata : $urandom;
            @(negedge clk);
            mem_rvalid = 1'b0;
        end
        exp_ld = ref_load(size, sext, addr, rdata);
        check_eq("ld_valid", 32'(ld_valid), 32'd1);
        check_eq("ld_data", ld_data, exp_ld);
        check_eq("ld_done_stall", 32'(stall), 32'd0);
        check_eq("ld_done_mis", 32'(misalign), 32'd0);
        op_valid = 1'b0;
        @(negedge clk);
        check_eq("ld_valid_once", 32'(ld_valid), 32'd0);
        check_eq("ld_data_hold", ld_data, exp_ld);
    endtask

    initial begin
        reset = 1'b1;
        op_valid = 1'b0; op_load = 1'b0; op_store = 1'b0; op_sext = 1'b0;
        op_size = 2'b00; op_addr = 32'h0; op_wdata = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_ldv", 32'(ld_valid), 32'd0);
        check_eq("rst_mis", 32'(misalign), 32'd0);
        check_eq("rst_req", 32'(mem_req), 32'd0);
        check_eq("rst_we", 32'(mem_we), 32'd0);
        check_eq("rst_addr", mem_addr, 32'h0);
        check_eq("rst_be", 32'(mem_be), 32'h0);
        check_eq("rst_wdata", mem_wdata, 32'h0);
        check_eq("rst_lddata", ld_data, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // op_valid without load/store is not accepted
        op_valid = 1'b1;
        #1;
        check_eq("noop_stall", 32'(stall), 32'd0);
        @(negedge clk);
        check_eq("noop_req", 32'(mem_req), 32'd0);
        op_valid = 1'b0;

        // directed cases
        run_op(1'b1, 0, 1'b0, 32'h0000_1003, 32'h0000_00AB, 0, 0, 32'h0, 1'b0);
        run_op(1'b0, 1, 1'b1, 32'h0000_1002, 32'h0, 0, 0, 32'h8001_7FFF, 1'b0);
        check_eq("dir_half_sext", ld_data, 32'hFFFF_8001);
        run_op(1'b0, 0, 1'b0, 32'h0000_1001, 32'h0, 0, 0, 32'h1122_33F4, 1'b0);
        check_eq("dir_byte_zext", ld_data, 32'h0000_0033);
        run_op(1'b0, 0, 1'b1, 32'h0000_1000, 32'h0, 0, 0, 32'h1122_33F4, 1'b0);
        check_eq("dir_byte_sext", ld_data, 32'hFFFF_FFF4);
        run_op(1'b0, 2, 1'b0, 32'h0000_1002, 32'h0, 0, 0, 32'h0, 1'b0);
        run_op(1'b1, 3, 1'b0, 32'h0000_1000, 32'h1234_5678, 0, 0, 32'h0, 1'b0);
        check_eq("dir_mis_keep", ld_data, 32'hFFFF_FFF4);
        run_op(1'b0, 2, 1'b0, 32'h0000_2000, 32'h0, 3, 1, 32'hCAFE_F00D, 1'b1);
        check_eq("dir_slow_word", ld_data, 32'hCAFE_F00D);

        // reset while waiting for read data
        op_valid = 1'b1; op_store = 1'b0; op_load = 1'b1; op_size = 2'b10;
        op_sext = 1'b0; op_addr = 32'h0000_3000;
        @(negedge clk);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check_eq("rstw_wait_stall", 32'(stall), 32'd1);
        reset = 1'b1;
        op_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check_eq("rstw_stall", 32'(stall), 32'd0);
        check_eq("rstw_req", 32'(mem_req), 32'd0);
        check_eq("rstw_ldv", 32'(ld_valid), 32'd0);
        exp_ld = 32'h0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check_eq("rstw_late_ldv", 32'(ld_valid), 32'd0);
        @(negedge clk);
        check_eq("rstw_late_ldv2", 32'(ld_valid), 32'd0);
        check_eq("rstw_lddata", ld_data, exp_ld);

        // random traffic
        for (int n = 0; n < 300; n++) begin
            int size;
            logic [31:0] addr;
            size = int'($urandom_range(0, 3));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (size == 1) addr = addr & 32'hFFFF_FFFE;
                if (size == 2) addr = addr & 32'hFFFF_FFFC;
            end
            run_op(1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)), addr,
                   $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   $urandom, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the CPU-to-data-memory interface, located in the MEM stage.
- Takes one load or store per instruction from the pipeline and issues a word-aligned request with byte enables over a req/gnt + rvalid handshake.
- For loads, selects the addressed lane from the returned word and zero- or sign-extends it.
- Stalls the pipeline while a request is outstanding and flags misaligned accesses without issuing them.

Parameters:
ADDR_W, 32, byte-address width.
DATA_W, 32, data word width; fixed at 32, other values unsupported.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
op_valid  in  1  MEM-stage instruction is a memory op
op_load  in  1  load request
op_store  in  1  store request; wins if both load and store asserted
op_size  in  2  00 byte, 01 half, 10 word, 11 illegal
op_sext  in  1  1 sign-extend load result, 0 zero-extend
op_addr  in  32  byte address
op_wdata  in  32  store data, right-justified
stall  out  1  hold pipeline (combinational)
ld_valid  out  1  one-cycle pulse: load result valid
ld_data  out  32  aligned and extended load result
misalign  out  1  one-cycle pulse: access rejected
mem_req  out  1  request valid
mem_we  out  1  1 write, 0 read
mem_addr  out  32  {op_addr[31:2],2'b00}
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read word

Behaviour:
- Reset state: state IDLE; all outputs 0; ld_data 0.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - Accept condition: op_valid & (op_load|op_store).
  - On accept with aligned access: register mem_we, mem_addr, mem_be, mem_wdata, op_sext and lane; next state REQ.
  - On accept with misaligned access or op_size=11: no request issued; next state DONE with misalign set.
- REQ:
  - mem_req=1; mem_we, mem_addr, mem_be and mem_wdata held stable until mem_gnt.
  - On gnt: a store goes to DONE; a load goes to WAIT.
- WAIT:
  - mem_req=0.
  - On mem_rvalid: capture the extracted and extended lane into ld_data; next state DONE.
  - mem_rvalid arrives no earlier than the cycle after gnt. Any rvalid received outside WAIT is ignored.
- DONE:
  - ld_valid=1 for a completed load; misalign=1 for a rejected access; both for one cycle only.
  - Always returns to IDLE, and never accepts a new op in this cycle.
- stall = (state==REQ) | (state==WAIT) | (state==IDLE & accept). stall is 0 in DONE, so the pipeline advances at the DONE edge.
- Pipeline holds all op_* inputs stable while stall=1.
- Alignment rules: half requires addr[0]=0; word requires addr[1:0]=00.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<{addr[1],1'b0}
  - word: 4'b1111
- Store data:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load extraction:
  - byte lane = rdata[8*addr[1:0]+:8]
  - half lane = rdata[16*addr[1]+:16]
  - Extension: with op_sext=1, the lane MSB fills the upper bits; otherwise zero fill.
- ld_data holds its value until the next load completes.
- Latency: a load with gnt in the first REQ cycle and rvalid one cycle later completes 4 cycles after accept (IDLE, REQ, WAIT, DONE). A store with immediate gnt takes 3 cycles.
- Reset mid-operation: the next state is IDLE and mem_req drops in the cycle after reset. The memory shares the same reset, so the dropped transaction is abandoned.

Decomposition:
- Shared constants header holds:
  - size codes SIZE_B/SIZE_H/SIZE_W
  - state encodings MAU_IDLE/MAU_REQ/MAU_WAIT/MAU_DONE
- One sub-module, load_align: a combinational lane select plus extend, taking inputs rdata, lane, size and sext and producing a 32-bit result.

Test Plan:
- Store byte, addr 0x00001003, wdata 0x000000AB, gnt in the first REQ cycle -> mem_addr 0x00001000, mem_be 4'b1000, mem_wdata 0xABABABAB, mem_we 1; stall high for 2 cycles, then low in DONE.
- Load half with sext, addr 0x00001002, rdata 0x80017FFF -> ld_data 0xFFFF8001; ld_valid pulses exactly 1 cycle, 3 cycles after accept.
- Load byte with zero extension, addr 0x00001001, rdata 0x112233F4 -> ld_data 0x00000033. Repeat with sext and addr 0x00001000 -> 0xFFFFFFF4.
- Word access at addr 0x00001002, and size 11 at addr 0x00001000 -> misalign pulses 1 cycle; mem_req never asserted; ld_data unchanged.
- Load with mem_gnt delayed 3 cycles -> mem_req, mem_addr and mem_be stable for all 4 REQ cycles; stall held throughout; a spurious rvalid during REQ is ignored.
- reset asserted in WAIT -> the next cycle shows state IDLE, stall 0, mem_req 0; a later mem_rvalid produces no ld_valid.
